// File: rtl/rr_priority_encoder.sv
// Registered priority encoder with fixed/round-robin arbitration and a valid/ready output stage.
// Define RRPE_ONEHOT_EN to add the registered one-hot grant output grant_oh.
module rr_priority_encoder #(
   parameter int OUT_SIZE = 2,
   parameter int IN_SIZE  = 1 << OUT_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IN_SIZE-1:0]  in,
   input  logic                enable,
   input  logic                mode,
   output logic                in_ready,
   output logic [OUT_SIZE-1:0] out,
   output logic                out_valid,
`ifdef RRPE_ONEHOT_EN
   output logic [IN_SIZE-1:0]  grant_oh,
`endif
   input  logic                out_ready
);

   logic [OUT_SIZE-1:0] ptr;
   logic [OUT_SIZE-1:0] fx_win;
   logic [OUT_SIZE-1:0] rr_win;
   logic [OUT_SIZE-1:0] win;
   logic                cap;
   int                  idx;

   assign in_ready = !out_valid | out_ready;
   assign cap      = enable & (|in) & in_ready;
   assign win      = mode ? rr_win : fx_win;

   always_comb begin
      fx_win = '0;
      rr_win = '0;
      idx    = 0;
      for (int i = 0; i < IN_SIZE; i++) begin
         if (|(in & (IN_SIZE'(1) << i))) fx_win = OUT_SIZE'(i);
      end
      // Walk the search order backwards so the nearest set line after ptr is written last.
      for (int k = IN_SIZE; k >= 1; k--) begin
         idx = int'(ptr) + k;
         if (idx >= IN_SIZE) idx = idx - IN_SIZE;
         if (|(in & (IN_SIZE'(1) << idx))) rr_win = OUT_SIZE'(idx);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         ptr       <= OUT_SIZE'(IN_SIZE - 1);
      end else if (cap) begin
         out       <= win;
         out_valid <= 1'b1;
         if (mode) ptr <= win;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef RRPE_ONEHOT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_oh <= '0;
      end else if (cap) begin
         grant_oh <= IN_SIZE'(1) << win;
      end else if (out_valid && out_ready) begin
         grant_oh <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: a 4-line and a 5-line instance driven side by side.
module tb_rr_priority_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       mode = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] in4 = '0;
   logic [4:0] in5 = '0;
   logic       rdy4, rdy5, v4, v5;
   logic [1:0] o4;
   logic [2:0] o5;
`ifdef RRPE_ONEHOT_EN
   logic [3:0] g4;
   logic [4:0] g5;
`endif

   always #5 clk = ~clk;

   rr_priority_encoder #(.OUT_SIZE(2), .IN_SIZE(4)) dut4 (
      .clk(clk), .rst(rst), .in(in4), .enable(enable), .mode(mode),
      .in_ready(rdy4), .out(o4), .out_valid(v4),
`ifdef RRPE_ONEHOT_EN
      .grant_oh(g4),
`endif
      .out_ready(out_ready));

   rr_priority_encoder #(.OUT_SIZE(3), .IN_SIZE(5)) dut5 (
      .clk(clk), .rst(rst), .in(in5), .enable(enable), .mode(mode),
      .in_ready(rdy5), .out(o5), .out_valid(v5),
`ifdef RRPE_ONEHOT_EN
      .grant_oh(g5),
`endif
      .out_ready(out_ready));

   int vectors = 0;
   int miscompares = 0;
   int q4[$];
   int q5[$];
   bit mv[2];
   bit mvn[2];
   int mp[2];
   int nsz[2] = '{4, 5};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: fixed = highest set line; round-robin = first set line after p, wrapping.
   function automatic int ref_win(input int vec, input int n, input bit rr, input int p);
      if (!rr) begin
         for (int i = n - 1; i >= 0; i--)
            if (((vec >> i) & 1) != 0) return i;
      end else begin
         for (int k = 1; k <= n; k++) begin
            int j;
            j = (p + k) % n;
            if (((vec >> j) & 1) != 0) return j;
         end
      end
      return -1;
   endfunction

   task automatic model_cycle(input int inst, input int vec);
      bit cap;
      int w;
      cap = enable && (vec != 0) && (!mv[inst] || out_ready);
      if (cap) begin
         w = ref_win(vec, nsz[inst], mode, mp[inst]);
         if (inst == 0) q4.push_back(w);
         else q5.push_back(w);
         if (mode) mp[inst] = w;
         mvn[inst] = 1'b1;
      end else if (mv[inst] && out_ready) begin
         mvn[inst] = 1'b0;
      end else begin
         mvn[inst] = mv[inst];
      end
   endtask

   task automatic step(input bit en, input bit md, input int a, input int b, input bit rdy);
      @(posedge clk);
      #1;
      mv[0] = mvn[0];
      mv[1] = mvn[1];
      enable    = en;
      mode      = md;
      in4       = 4'(a);
      in5       = 5'(b);
      out_ready = rdy;
      model_cycle(0, a);
      model_cycle(1, b);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_out4", 32'(o4), 0);
      chk("rst_valid4", 32'(v4), 0);
      chk("rst_out5", 32'(o5), 0);
      chk("rst_valid5", 32'(v5), 0);
      q4.delete();
      q5.delete();
      mv  = '{1'b0, 1'b0};
      mvn = '{1'b0, 1'b0};
      mp  = '{3, 4};
      enable = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("valid4", 32'(v4), 32'(mv[0]));
         chk("in_ready4", 32'(rdy4), 32'(!mv[0] || out_ready));
         chk("valid5", 32'(v5), 32'(mv[1]));
         chk("in_ready5", 32'(rdy5), 32'(!mv[1] || out_ready));
         if (v4 === 1'b1) begin
            chk("pending4", 32'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
               chk("out4", 32'(o4), q4[0]);
`ifdef RRPE_ONEHOT_EN
               chk("grant4", 32'(g4), 32'(1) << q4[0]);
`endif
               if (out_ready) void'(q4.pop_front());
            end
         end else begin
`ifdef RRPE_ONEHOT_EN
            chk("grant4_idle", 32'(g4), 0);
`endif
         end
         if (v5 === 1'b1) begin
            chk("range5", 32'(o5 < 3'd5), 1);
            chk("pending5", 32'(q5.size() != 0), 1);
            if (q5.size() != 0) begin
               chk("out5", 32'(o5), q5[0]);
`ifdef RRPE_ONEHOT_EN
               chk("grant5", 32'(g5), 32'(1) << q5[0]);
`endif
               if (out_ready) void'(q5.pop_front());
            end
         end
      end
   end

   initial begin
      do_reset();
      // fixed priority: 1011 -> 3, 0001 -> 0, then idle drains
      step(1, 0, 4'b1011, 5'b10001, 1);
      step(1, 0, 4'b0001, 5'b00011, 1);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      // round-robin sweep 0,1,2,3,0 then 0101 -> 2,0,2; 5-line alternates 0,4
      repeat (5) step(1, 1, 4'b1111, 5'b10001, 1);
      repeat (3) step(1, 1, 4'b0101, 5'b10001, 1);
      // backpressure with changing requests, then pop+capture on the same edge
      step(1, 1, 4'b0010, 5'b10001, 0);
      step(1, 1, 4'b1000, 5'b00100, 0);
      step(1, 0, 4'b0100, 5'b01000, 0);
      step(1, 0, 4'b0001, 5'b00010, 0);
      step(1, 0, 4'b0110, 5'b10010, 1);
      step(1, 0, 4'b0110, 5'b10010, 1);
      // disable with result pending, then pop
      step(0, 1, 4'b1111, 5'b11111, 0);
      step(0, 1, 4'b1111, 5'b11111, 1);
      step(0, 1, 4'b1111, 5'b11111, 1);
      // reset mid-transfer, then first RR grant must be line 0
      step(1, 1, 4'b1111, 5'b11111, 0);
      step(1, 1, 4'b1111, 5'b11111, 0);
      do_reset();
      repeat (3) step(1, 1, 4'b1111, 5'b11111, 1);
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
              $urandom_range(0, 9) < 7);
      end
      repeat (3) step(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("drained4", 32'(q4.size()), 0);
      chk("drained5", 32'(q5.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
